// File: rtl/fifo_flex_pkg.sv
// Shared types, helpers and parameter-legality checks for the fifo_flex slice.
package fifo_flex_pkg;

    // Read-port behaviour: registered pop or first-word-fall-through.
    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    localparam int MIN_DEPTH = 4;

    // Memory address width for a given number of entries.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // True when depth is a power of two >= MIN_DEPTH and both thresholds are in range.
    function automatic bit params_ok(input int depth, input int af_thresh, input int ae_thresh);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module fifo_flex_mem
    import fifo_flex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Storage is never reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with selectable registered/FWFT read, threshold flags,
// fill level and sticky overflow/underflow flags.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 128,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    localparam int AW       = addr_w(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic             i_clk,
    input  logic             arst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             o_rd_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow,
    output logic             o_underflow,
    input  logic             i_clr_err
);

    localparam rd_mode_e      RD_MODE   = (FWFT != 0) ? RD_FWFT : RD_REG;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL    = CW'(AE_THRESH);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH) || (WIDTH < 1) || (FWFT < 0) || (FWFT > 1)) begin : g_param_err
        $error("fifo_flex: illegal parameters (DEPTH pow2 >= 4, 1<=AF_THRESH<=DEPTH, 0<=AE_THRESH<DEPTH, FWFT 0/1)");
    end

    // Pointers carry a wrap bit above the memory address bits.
    logic [CW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             overflow_reg, underflow_reg;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] mem_rd_data;

    // Flags come straight from the registered count, no extra latency.
    assign o_empty        = (count_reg == '0);
    assign o_full         = (count_reg == FULL_LVL);
    assign o_almost_full  = (count_reg >= AF_LVL);
    assign o_almost_empty = (count_reg <= AE_LVL);
    assign o_count        = count_reg;
    assign o_overflow     = overflow_reg;
    assign o_underflow    = underflow_reg;

    // A write into a full FIFO is fine when the same edge pops a word.
    assign rd_acc = rd_en & ~o_empty;
    assign wr_acc = wr_en & (~o_full | rd_acc);

    // Occupancy moves by the net of accepted writes and reads.
    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer, count and sticky error state; a set on the same edge beats a clear.
    always_ff @(posedge i_clk or posedge arst) begin
        if (arst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + CW'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + CW'(1);
            count_reg     <= count_next;
            overflow_reg  <= (wr_en & ~wr_acc) | (overflow_reg & ~i_clr_err);
            underflow_reg <= (rd_en & ~rd_acc) | (underflow_reg & ~i_clr_err);
        end
    end

    fifo_flex_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    if (RD_MODE == RD_REG) begin : g_rd_reg
        logic [WIDTH-1:0] rd_data_reg;
        logic             rd_valid_reg;

        // Capture the head word on a pop; valid pulses for the following cycle.
        always_ff @(posedge i_clk or posedge arst) begin
            if (arst) begin
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= rd_acc;
                if (rd_acc) rd_data_reg <= mem_rd_data;
            end
        end

        assign rd_data    = rd_data_reg;
        assign o_rd_valid = rd_valid_reg;
    end else begin : g_rd_fwft
        // Head word is visible whenever something is stored; zero when empty.
        assign rd_data    = o_empty ? '0 : mem_rd_data;
        assign o_rd_valid = ~o_empty;
    end

    // Wrapped pointer distance must always equal the tracked occupancy.
    a_ptr_count: assert property (@(posedge i_clk) disable iff (arst)
        (wr_ptr_reg - rd_ptr_reg) == count_reg);

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: one registered-read and one FWFT instance share stimulus;
// a queue model predicts occupancy, flags and popped data.
module tb_fifo_flex;
    import fifo_flex_pkg::*;

    localparam int W = 16;
    localparam int D = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [W-1:0] wr_data = '0;

    logic [W-1:0] r_rd_data, f_rd_data;
    logic         r_rd_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic         f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]   r_count, f_count;

    fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_reg (
        .i_clk(clk), .arst(arst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(r_rd_data), .o_rd_valid(r_rd_valid), .o_full(r_full), .o_empty(r_empty),
        .o_almost_full(r_af), .o_almost_empty(r_ae), .o_count(r_count),
        .o_overflow(r_ovf), .o_underflow(r_unf), .i_clr_err(clr));

    fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_fwft (
        .i_clk(clk), .arst(arst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .o_rd_valid(f_rd_valid), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf), .i_clr_err(clr));

    always #5 clk = ~clk;

    // Reference model: stored words, words awaiting the registered read port, sticky flags.
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    bit           m_ovf, m_unf, m_rv;
    bit           chk_en = 1'b0;
    int           n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0;
    endtask

    // Drive one cycle of stimulus (called at a falling edge) and advance the model.
    task automatic step(input bit we, input logic [W-1:0] wd, input bit re, input bit cl);
        bit rok, wok;
        wr_en = we; wr_data = wd; rd_en = re; clr = cl;
        rok = re && (mq.size() > 0);
        wok = we && ((mq.size() < D) || rok);
        if (rok) exp_q.push_back(mq.pop_front());
        if (wok) mq.push_back(wd);
        m_ovf = (we && !wok) || (m_ovf && !cl);
        m_unf = (re && !rok) || (m_unf && !cl);
        m_rv  = rok;
        $display("txn we=%0d wd=%04h re=%0d clr=%0d -> wacc=%0d racc=%0d level=%0d",
                 we, wd, re, cl, wok, rok, mq.size());
        @(negedge clk);
    endtask

    // Monitor: compare DUT state to the model after every rising edge.
    always @(posedge clk) begin
        #2;
        if (chk_en && !arst) begin
            chk("r_count", r_count, mq.size());
            chk("r_full", r_full, mq.size() == D);
            chk("r_empty", r_empty, mq.size() == 0);
            chk("r_almost_full", r_af, mq.size() >= AF);
            chk("r_almost_empty", r_ae, mq.size() <= AE);
            chk("r_overflow", r_ovf, m_ovf);
            chk("r_underflow", r_unf, m_unf);
            chk("r_rd_valid", r_rd_valid, m_rv);
            if (r_rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL r_pop: got %04h, expected no word", r_rd_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("r_rd_data", r_rd_data, e);
                end
            end
            chk("f_count", f_count, mq.size());
            chk("f_empty", f_empty, mq.size() == 0);
            chk("f_full", f_full, mq.size() == D);
            chk("f_rd_valid", f_rd_valid, mq.size() != 0);
            chk("f_overflow", f_ovf, m_ovf);
            chk("f_underflow", f_unf, m_unf);
            if (mq.size() != 0) chk("f_rd_data", f_rd_data, mq[0]);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_r_count"}, r_count, 0);
        chk({tag, "_r_empty"}, r_empty, 1);
        chk({tag, "_r_ae"}, r_ae, 1);
        chk({tag, "_r_full"}, r_full, 0);
        chk({tag, "_r_af"}, r_af, 0);
        chk({tag, "_r_ovf"}, r_ovf, 0);
        chk({tag, "_r_unf"}, r_unf, 0);
        chk({tag, "_r_rd_valid"}, r_rd_valid, 0);
        chk({tag, "_r_rd_data"}, r_rd_data, 0);
        chk({tag, "_f_empty"}, f_empty, 1);
        chk({tag, "_f_count"}, f_count, 0);
        chk({tag, "_f_rd_data"}, f_rd_data, 0);
    endtask

    initial begin
        if (!params_ok(D, AF, AE)) begin
            $display("FAIL params: bench parameters illegal");
            $fatal(1);
        end
        model_reset();
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        arst = 1'b0;
        chk_en = 1'b1;

        // FWFT: a word written into an empty FIFO shows up without rd_en.
        step(1, 16'hBEEF, 0, 0);
        chk("fwft_beef", f_rd_data, 16'hBEEF);
        step(0, 0, 1, 0);
        chk("fwft_pop_empty", f_empty, 1);
        step(0, 0, 0, 0);

        // Fill: ten writes, the last two rejected.
        for (int i = 1; i <= 10; i++) step(1, W'(i), 0, 0);
        chk("fill_count", r_count, 8);
        chk("fill_overflow", r_ovf, 1);

        // Drain: ten reads, data 1..8 then underflow.
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        chk("drain_underflow", r_unf, 1);
        step(0, 0, 0, 1);
        chk("clr_ovf", r_ovf, 0);
        chk("clr_unf", r_unf, 0);

        // Simultaneous read+write while full, then while empty.
        for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) step(1, W'($urandom), 1, 0);
        chk("full_rw_count", r_count, 8);
        chk("full_rw_full", r_full, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(1, 16'h0A5A, 1, 0);
        chk("empty_rw_count", r_count, 1);
        chk("empty_rw_unf", r_unf, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Wrap-around: three passes of eight writes then eight reads.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 0);
            for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        end

        // Random traffic with alternating write/read bias.
        for (int i = 0; i < 300; i++) begin
            int wb;
            wb = ((i / 40) % 2 == 0) ? 75 : 30;
            step($urandom_range(0, 99) < wb, W'($urandom), $urandom_range(0, 99) >= wb,
                 $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 9; i++) step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Reset with five words stored: outputs clear before any clock edge.
        for (int i = 0; i < 6; i++) step(1, W'(16'h0100 + i), 0, 0);
        step(0, 0, 1, 0);
        chk("pre_reset_count", r_count, 5);
        chk_en = 1'b0;
        #3 arst = 1'b1;
        #1 chk_reset_outputs("midreset");
        wr_en = 0; rd_en = 0; clr = 0;
        @(negedge clk);
        arst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step(1, 16'h1234, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
